// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline-control slice of the RV32I core:
//   - stall/flush FSM state encoding (RUN, MEM_WAIT, REDIR), exposed on
//     hazard_ctrl.ctrl_state for debug
//   - major opcode constants shared with the forwarding and decode units
package hazard_ctrl_pkg;

    // FSM state encoding; the values are visible on the debug port.
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIR    = 2'd2;

    // RV32I major opcodes (instr[6:0]).
    typedef enum logic [6:0] {
        OP_RR     = 7'b0110011,
        OP_JAL    = 7'b1101111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    // True for instructions that reach dmem in the MEM stage.
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
//   Saturating event counter used for stall/flush statistics.
//   Ports:
//     clk    core clock
//     rst    asynchronous, active-high reset (count -> 0)
//     inc    count one event this cycle
//     count  current value; sticks at all-ones
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Stall/flush controller for the 5-stage RV32I pipeline. Turns load-use
//   requests, EX-stage redirects and the dmem handshake into per-stage
//   write enables, bubbles and flushes. Outputs are combinational (no added
//   latency); only the FSM state and the redirect flush counter are stored.
//   Priority each cycle: dmem freeze > redirect > load-use > normal.
//
//   Parameters:
//     REDIRECT_FLUSH  extra cycles IF/ID is flushed after a redirect (0..3)
//     CNT_W           width of the optional performance counters
//   Ports:
//     clk, rst                         core clock, async active-high reset
//     load_stall_rs1/rs2               load-use requests from forwarding
//     ex_redirect                      taken branch/JAL/JALR in EX
//     dmem_req, dmem_ready             MEM-stage dmem handshake
//     pc_we, ifid_we, idex_we, exmem_we  stage register write enables
//     ifid_flush, idex_bubble, memwb_bubble  load NOP into that register
//     ctrl_state                       current FSM state (debug)
//   Build option:
//     HAZARD_PERF_EN  adds saturating stall_cycles / flush_cycles counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_FLUSH = 1,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_stall_rs1,
    input  logic       load_stall_rs2,
    input  logic       ex_redirect,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_we,
    output logic       idex_bubble,
    output logic       exmem_we,
    output logic       memwb_bubble,
    output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
`endif
);

    localparam logic [1:0] FLUSH_LOAD = 2'(REDIRECT_FLUSH);

    logic [1:0] state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       ls;
    logic       freeze;

    assign ls     = load_stall_rs1 | load_stall_rs2;
    assign freeze = dmem_req & ~dmem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        // Normal flow unless a hazard overrides it below.
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;
        state_next   = ST_RUN;
        cnt_next     = cnt_reg;

        if (rst) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            cnt_next     = '0;
        end else if (freeze) begin
            // Whole pipe holds; MEM's result is not valid yet, so WB gets a NOP.
            // A pending redirect stays asserted in EX and is taken at release.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            state_next   = ST_MEM_WAIT;
        end else if (ex_redirect) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed, so a
            // load-use request from them is meaningless and ignored.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cnt_next    = FLUSH_LOAD;
            state_next  = (REDIRECT_FLUSH > 0) ? ST_REDIR : ST_RUN;
        end else if (state_reg == ST_REDIR) begin
            // Instruction memory still returning wrong-path fetches.
            ifid_flush = 1'b1;
            if (cnt_reg <= 2'd1) begin
                cnt_next   = '0;
                state_next = ST_RUN;
            end else begin
                cnt_next   = cnt_reg - 2'd1;
                state_next = ST_REDIR;
            end
        end else if (ls) begin
            // Hold PC and IF/ID, insert one bubble behind the load.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign ctrl_state = state_reg;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~rst & ~pc_we),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~rst & ifid_flush),
        .count (flush_cycles)
    );
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline-control end of the operand-forwarding path for the 5-stage RV32I core.
- Consumes the load-use stall requests raised by the two per-operand forwarding units (rs1, rs2), EX-stage redirects, and the data-memory handshake.
- Produces the per-stage write enables, bubbles and flushes that realise those requests.
- Sits beside the stage registers; owns the only stall/flush state machine in the core.

Parameters:
- REDIRECT_FLUSH, 1, extra cycles IF/ID is flushed after a redirect (covers synchronous imem latency); legal 0..3.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- load_stall_rs1  input  1  load-use request from rs1 forwarding unit
- load_stall_rs2  input  1  load-use request from rs2 forwarding unit
- ex_redirect  input  1  taken branch / JAL / JALR resolved in EX this cycle
- dmem_req  input  1  MEM-stage instruction is a load/store accessing dmem
- dmem_ready  input  1  dmem completes the access this cycle
- pc_we  output  1  PC register write enable
- ifid_we  output  1  IF/ID register write enable
- ifid_flush  output  1  load NOP into IF/ID
- idex_we  output  1  ID/EX register write enable
- idex_bubble  output  1  load NOP into ID/EX
- exmem_we  output  1  EX/MEM register write enable
- memwb_bubble  output  1  load NOP into MEM/WB
- ctrl_state  output  2  current FSM state (debug)

Behaviour:
- States (2-bit encoding): RUN=0, MEM_WAIT=1, REDIR=2. Reset: state=RUN, flush counter=0.
- While rst is high: pc_we, ifid_we, idex_we, exmem_we = 0; ifid_flush, idex_bubble, memwb_bubble = 1.
- Outputs are combinational from state, counter and inputs. Zero cycles of added latency.
- ls = load_stall_rs1 | load_stall_rs2. freeze = dmem_req & ~dmem_ready.
- Priority each cycle: freeze > redirect > load-use > normal.
- freeze: all *_we = 0, memwb_bubble = 1, other bubbles/flushes = 0. Next state MEM_WAIT.
- MEM_WAIT: stay while freeze. On dmem_ready, apply normal RUN evaluation this same cycle, including redirect and ls; next state follows from that.
- ex_redirect, not frozen:
  - pc_we = 1, ifid_flush = 1, idex_bubble = 1, all we = 1, memwb_bubble = 0.
  - Load counter with REDIRECT_FLUSH. Next state REDIR if REDIRECT_FLUSH > 0, else RUN.
  - ls is ignored in this cycle (wrong-path consumer).
- REDIR, not frozen:
  - ifid_flush = 1 and ls is ignored (IF/ID content is wrong-path). Decrement counter; return to RUN when it reaches 1.
  - A new ex_redirect in REDIR reloads the counter.
- load-use (ls, RUN, no redirect, not frozen):
  - pc_we = 0, ifid_we = 0, idex_bubble = 1, idex_we = 1, exmem_we = 1.
  - Stays in RUN. The forwarding unit deasserts ls next cycle once the load reaches MEM.
  - ls held for N cycles yields exactly N bubbles; no internal limit.
- normal: all we = 1, all flush/bubble = 0.
- ex_redirect while frozen: ignored. EX is held, so the redirect stays asserted and is acted on at release.
- Reset mid-operation: immediate return to reset outputs; counter cleared.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles[CNT_W-1:0] and flush_cycles[CNT_W-1:0]. Both reset to 0 and saturate at all-ones.
  - stall_cycles increments on any cycle with pc_we = 0 and rst low.
  - flush_cycles increments on any cycle with ifid_flush = 1 and rst low.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package: state encoding constants (RUN/MEM_WAIT/REDIR), opcode constants (RR, JAL, Branch, Load, Store, Imm, LUI, AUIPC, JALR) shared with the forwarding and decode units.
- One natural sub-module: hazard_perf_cnt, a saturating counter instantiated twice under HAZARD_PERF_EN.

Test Plan:
- Reset: rst=1 with load_stall_rs1=1 -> pc_we=0, idex_bubble=1, ctrl_state=0. Release rst, all inputs 0 -> all we=1, bubbles 0.
- Load-use: load_stall_rs2=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1 that cycle only. Next cycle normal. With HAZARD_PERF_EN, stall_cycles=1.
- Redirect, REDIRECT_FLUSH=1: ex_redirect=1 with load_stall_rs1=1 -> pc_we=1, ifid_flush=1, idex_bubble=1. Next cycle ifid_flush=1, state=2, ls ignored. Third cycle state=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, ex_redirect=1 -> all we=0, memwb_bubble=1 for 3 cycles, state=1. 4th cycle dmem_ready=1 -> redirect applied, state=2.
- Back-to-back redirects: ex_redirect in two consecutive cycles, REDIRECT_FLUSH=2 -> ifid_flush high for 4 cycles total, then state=0.
- Async reset mid-MEM_WAIT: rst pulses high between clock edges -> state=0 immediately, counters=0, outputs at reset values without waiting for clk.
